kernel_sysid_ext: RTL

- Parametrised next-generation system-identification Avalon-MM slave for the Qsys/Nios II system.
- Adds the following over a fixed ID responder:
  - multi-register map,
  - registered reads with readdatavalid,
  - writable scratch register,
  - prescaled 64-bit uptime counter with coherent high-word snapshot.
- Software reads it at boot to confirm hardware/software match and to measure uptime.

---
 rtl/kernel_sysid_pkg.sv | 26 ++
 rtl/kernel_sysid_uptime.sv | 56 +++++
 rtl/kernel_sysid_ext.sv | 122 ++++++++++++
 3 files changed

// File: rtl/kernel_sysid_pkg.sv
// ============================================================================
// Module      : kernel_sysid_pkg
// Description : Register offsets, CTRL bit positions and widths for kernel_sysid_ext.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kernel_sysid_pkg;

   localparam int UPTIME_W = 64;

   typedef logic [2:0] reg_off_t;

   localparam reg_off_t OFF_ID      = 3'd0;
   localparam reg_off_t OFF_TS      = 3'd1;
   localparam reg_off_t OFF_SCRATCH = 3'd2;
   localparam reg_off_t OFF_UP_LO   = 3'd3;
   localparam reg_off_t OFF_UP_HI   = 3'd4;
   localparam reg_off_t OFF_CTRL    = 3'd5;

   localparam int CTRL_CLR  = 0;
   localparam int CTRL_WRAP = 1;

endpackage

`default_nettype wire

// File: rtl/kernel_sysid_uptime.sv
// ============================================================================
// Module      : kernel_sysid_uptime
// Description : Prescaled 64-bit uptime counter with clear input and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_sysid_uptime
   import kernel_sysid_pkg::*;
#(
   parameter int PRESCALE = 50
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                clr,
   output logic [UPTIME_W-1:0] count,
   output logic                wrap
);

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

   logic [15:0]         pre_q, pre_d;
   logic [UPTIME_W-1:0] cnt_q, cnt_d;
   logic                tick;

   always_comb begin
      tick  = (pre_q == PRE_MAX);
      pre_d = pre_q + 16'd1;
      cnt_d = cnt_q;
      if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + UPTIME_W'(1);
      end
      // Clear dominates a coincident tick.
      if (clr) begin
         pre_d = '0;
         cnt_d = '0;
      end
   end

   assign wrap  = tick & ~clr & (&cnt_q);
   assign count = cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/kernel_sysid_ext.sv
// ============================================================================
// Module      : kernel_sysid_ext
// Description : System-ID Avalon-MM slave with scratch register and, when
//               KERNEL_SYSID_UPTIME_EN is defined, a prescaled 64-bit uptime.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_sysid_ext
   import kernel_sysid_pkg::*;
#(
   parameter logic [31:0] ID_VALUE     = 32'h582B_96E3,
   parameter logic [31:0] TIMESTAMP    = 32'h0,
   parameter logic [31:0] SCRATCH_INIT = 32'h0,
   parameter int          PRESCALE     = 50,
   parameter int          DATA_W       = 32
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("kernel_sysid_ext: DATA_W must be 32");
   end

   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("kernel_sysid_ext: PRESCALE must be in 1..65535");
   end

   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic [DATA_W-1:0] rd_word;

`ifdef KERNEL_SYSID_UPTIME_EN
   logic [UPTIME_W-1:0] uptime_cnt;
   logic                wrap_pulse;
   logic                ctrl_wr;
   logic                clr;
   logic [DATA_W-1:0]   shadow_q, shadow_d;
   logic                wrap_q, wrap_d;

   assign ctrl_wr = write && (address == OFF_CTRL);
   assign clr     = ctrl_wr && writedata[CTRL_CLR];

   kernel_sysid_uptime #(
      .PRESCALE (PRESCALE)
   ) u_uptime (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (clr),
      .count   (uptime_cnt),
      .wrap    (wrap_pulse)
   );
`endif

   always_comb begin
      rd_word = '0;
      case (address)
         OFF_ID:      rd_word = ID_VALUE;
         OFF_TS:      rd_word = TIMESTAMP;
         OFF_SCRATCH: rd_word = scratch_q;
`ifdef KERNEL_SYSID_UPTIME_EN
         OFF_UP_LO:   rd_word = uptime_cnt[31:0];
         OFF_UP_HI:   rd_word = shadow_q;
         OFF_CTRL:    rd_word[CTRL_WRAP] = wrap_q;
`endif
         default:     rd_word = '0;
      endcase

      rvalid_d  = read;
      rdata_d   = read ? rd_word : rdata_q;
      scratch_d = (write && (address == OFF_SCRATCH)) ? writedata : scratch_q;

`ifdef KERNEL_SYSID_UPTIME_EN
      // LO read latches the high word so a following HI read is coherent.
      shadow_d = (read && (address == OFF_UP_LO)) ? uptime_cnt[UPTIME_W-1:32] : shadow_q;
      if (wrap_pulse)
         wrap_d = 1'b1;
      else if (ctrl_wr && writedata[CTRL_WRAP])
         wrap_d = 1'b0;
      else
         wrap_d = wrap_q;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         scratch_q <= SCRATCH_INIT;
      end else begin
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         scratch_q <= scratch_d;
      end
   end

`ifdef KERNEL_SYSID_UPTIME_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= '0;
         wrap_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         wrap_q   <= wrap_d;
      end
   end
`endif

   assign readdata      = rdata_q;
   assign readdatavalid = rvalid_q;

endmodule

`default_nettype wire
